// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the five-stage pipeline.
//
// Accepts the registered EX-stage outputs. ALU ops pass straight through to WB
// with one cycle of latency. Loads and stores go out on a req/ack data-memory
// port with variable latency. EX is stalled for as long as an access is
// outstanding. An access with no ack within TIMEOUT_CYCLES cycles is aborted
// with a bus_err pulse.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   *_2_mem               EX-stage instruction fields (sampled only when idle)
//   stall_2_ex            high while a memory access is outstanding
//   dmem_req/we/addr/wdata  data-memory request, held stable until ack
//   dmem_rdata/ack        data-memory response
//   valid_2_wb            one-cycle result strobe to WB
//   wb_data_2_wb, rd_add_value_2_wb, reg_write_2_wb   write-back fields
//   misalign_err, bus_err one-cycle error pulses
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_2_mem,
  input  logic [31:0] alu_rd_2_mem,
  input  logic [31:0] addr_2_mem,
  input  logic [31:0] store_data_2_mem,
  input  logic        mem_read_2_mem,
  input  logic        mem_write_2_mem,
  input  logic        mem_to_reg_2_mem,
  input  logic [4:0]  rd_add_value_2_mem,
  output logic        stall_2_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_2_wb,
  output logic [31:0] wb_data_2_wb,
  output logic [4:0]  rd_add_value_2_wb,
  output logic        reg_write_2_wb,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic              valid_wb_q, valid_wb_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        rd_wb_q, rd_wb_d;
  logic              reg_write_q, reg_write_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic is_mem_op;
  logic aligned;

  // Loads always write back the memory data, so the mux select from EX is redundant here.
  logic unused_mem_to_reg;
  assign unused_mem_to_reg = mem_to_reg_2_mem;

  assign is_mem_op = mem_read_2_mem | mem_write_2_mem;
  assign aligned   = (addr_2_mem[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_lat_d    = rd_lat_q;
    wb_data_d   = wb_data_q;
    rd_wb_d     = rd_wb_q;
    // Strobes and the write enable are only ever high for one cycle.
    valid_wb_d  = 1'b0;
    reg_write_d = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_2_mem) begin
          if (!is_mem_op) begin
            valid_wb_d  = 1'b1;
            wb_data_d   = alu_rd_2_mem;
            rd_wb_d     = rd_add_value_2_mem;
            reg_write_d = (rd_add_value_2_mem != 5'd0);
          end else if (!aligned) begin
            valid_wb_d = 1'b1;
            misalign_d = 1'b1;
          end else begin
            addr_d   = addr_2_mem;
            wdata_d  = store_data_2_mem;
            we_d     = mem_write_2_mem;  // write wins when both are set
            rd_lat_d = rd_add_value_2_mem;
            req_d    = 1'b1;
            cnt_d    = '0;
            state_d  = StAccess;
          end
        end
      end

      StAccess: begin
        // Ack is checked first so a response on the final cycle beats the timeout.
        if (dmem_ack) begin
          req_d      = 1'b0;
          state_d    = StIdle;
          valid_wb_d = 1'b1;
          rd_wb_d    = rd_lat_q;
          if (!we_q) begin
            wb_data_d   = dmem_rdata;
            reg_write_d = (rd_lat_q != 5'd0);
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          req_d      = 1'b0;
          state_d    = StIdle;
          valid_wb_d = 1'b1;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_lat_q    <= '0;
      valid_wb_q  <= 1'b0;
      wb_data_q   <= '0;
      rd_wb_q     <= '0;
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_lat_q    <= rd_lat_d;
      valid_wb_q  <= valid_wb_d;
      wb_data_q   <= wb_data_d;
      rd_wb_q     <= rd_wb_d;
      reg_write_q <= reg_write_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign stall_2_ex        = (state_q == StAccess);
  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign valid_2_wb        = valid_wb_q;
  assign wb_data_2_wb      = wb_data_q;
  assign rd_add_value_2_wb = rd_wb_q;
  assign reg_write_2_wb    = reg_write_q;
  assign misalign_err      = misalign_q;
  assign bus_err           = bus_err_q;

endmodule
